// File: rtl/pe_fifo_arb_if.sv
// pe_fifo_arb_if: requester-FIFO read side and output stream of the round-robin FIFO arbiter.
interface pe_fifo_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) ();
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req_mask_i;
  logic [NUM_REQ-1:0]            fifo_empty_i;
  logic [NUM_REQ-1:0]            fifo_rd_en_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [DATA_WIDTH-1:0]         out_data_o;
  logic [IW-1:0]                 out_id_o;
  modport master (
    input  req_mask_i, fifo_empty_i, fifo_rd_data_i, out_ready_i,
    output fifo_rd_en_o, out_valid_o, out_data_o, out_id_o
  );
  modport slave (
    output req_mask_i, fifo_empty_i, fifo_rd_data_i, out_ready_i,
    input  fifo_rd_en_o, out_valid_o, out_data_o, out_id_o
  );
endinterface

// File: rtl/pe_fifo_arb.sv
// pe_fifo_arb: round-robin reader of NUM_REQ FIFOs into a 2-entry output buffer.
// Define PE_ARB_BURST_EN to let a requester keep up to BURST_LEN consecutive grants.
module pe_fifo_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input logic          clk,
  input logic          rst,
  pe_fifo_arb_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_param
    $error("pe_fifo_arb: parameter out of range");
  end
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_REQ);
  endfunction
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [IW-1:0]         buf_id [2];
  logic                  wr_ptr, rd_ptr, inflight, started, fire, space, grant, rr_found;
  logic [1:0]            count;
  logic [IW-1:0]         inflight_id, last, pick, rr_pick;
  logic [NUM_REQ-1:0]    elig;
  assign elig = bus.req_mask_i & ~bus.fifo_empty_i;
  assign bus.out_valid_o = !rst && count != 2'd0;
  assign bus.out_data_o = bus.out_valid_o ? buf_data[rd_ptr] : '0;
  assign bus.out_id_o = bus.out_valid_o ? buf_id[rd_ptr] : '0;
  assign fire = bus.out_valid_o && bus.out_ready_i;
  // a word leaving this cycle frees its slot for the read issued now
  assign space = ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, fire});
  always_comb begin
    rr_found = 1'b0;
    rr_pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!rr_found && elig[wrap(int'(last) + k)]) begin
        rr_found = 1'b1;
        rr_pick = wrap(int'(last) + k);
      end
    end
  end
`ifdef PE_ARB_BURST_EN
  logic [3:0] burst_cnt;
  logic       hold;
  assign hold = burst_cnt != 4'd0 && burst_cnt < 4'(BURST_LEN) && elig[last];
  assign pick = hold ? last : rr_pick;
  assign grant = started && !rst && space && (hold || rr_found);
  always_ff @(posedge clk) begin
    if (rst) burst_cnt <= '0;
    else if (grant) burst_cnt <= hold ? burst_cnt + 4'd1 : 4'd1;
    else if (!elig[last]) burst_cnt <= '0;
  end
`else
  assign pick = rr_pick;
  assign grant = started && !rst && space && rr_found;
`endif
  assign bus.fifo_rd_en_o = grant ? NUM_REQ'(1) << pick : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      started <= 1'b0;
      inflight <= 1'b0;
      inflight_id <= '0;
      last <= IW'(NUM_REQ - 1);
      count <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      started <= 1'b1;
      inflight <= grant;
      if (grant) begin
        inflight_id <= pick;
        last <= pick;
      end
      if (inflight) wr_ptr <= ~wr_ptr;
      if (fire) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, fire};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && inflight) begin
      buf_data[wr_ptr] <= bus.fifo_rd_data_i[int'(inflight_id)*DATA_WIDTH +: DATA_WIDTH];
      buf_id[wr_ptr] <= inflight_id;
    end
  end
endmodule

// File: tb/tb_pe_fifo_arb.sv
// tb_pe_fifo_arb: queue-based reference model of the FIFO arbiter, directed scenarios then random traffic.
module tb_pe_fifo_arb;
  localparam int N = 4;
  localparam int W = 16;
`ifdef PE_ARB_BURST_EN
  localparam int BL = 2;
`else
  localparam int BL = 4;
`endif
  typedef struct packed {logic [1:0] id; logic [W-1:0] d;} ent_t;
  logic clk, rst;
  int vectors, miscompares, cyc, rdc, rd2, vcnt;
  logic [W-1:0] q [N][$];
  ent_t mbuf[$];
  ent_t m_inf_e, pend_e;
  bit m_inf, m_started, pend_v;
  int m_last, m_cnt;
  int seen_id[$], seen_d[$], seen_cyc[$];
  pe_fifo_arb_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
  pe_fifo_arb #(.NUM_REQ(N), .DATA_WIDTH(W), .BURST_LEN(BL)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] mask, input logic ready, input logic r);
    logic [N-1:0] emp, exp_rd;
    logic [N*W-1:0] rd;
    bit ev, fire, space, found, hold;
    int pick;
    ent_t front;
    @(posedge clk);
    #1;
    rd = {$urandom, $urandom};
    if (pend_v) rd[int'(pend_e.id)*W +: W] = pend_e.d;
    pend_v = 0;
    for (int i = 0; i < N; i++) emp[i] = q[i].size() == 0;
    bus.fifo_rd_data_i = rd;
    bus.req_mask_i = mask;
    bus.fifo_empty_i = emp;
    bus.out_ready_i = ready;
    rst = r;
    #1;
    ev = !r && mbuf.size() > 0;
    front = ev ? mbuf[0] : '0;
    fire = ev && ready;
    space = (int'(mbuf.size()) + int'(m_inf) - int'(fire)) < 2;
    hold = 0;
`ifdef PE_ARB_BURST_EN
    hold = m_cnt > 0 && m_cnt < BL && mask[m_last] && !emp[m_last];
`endif
    found = hold;
    pick = m_last;
    for (int k = 1; k <= N && !found; k++) begin
      int c;
      c = (m_last + k) % N;
      if (mask[c] && !emp[c]) begin
        found = 1;
        pick = c;
      end
    end
    exp_rd = (m_started && !r && space && found) ? N'(1) << pick : '0;
    chk("rd_en", 32'(bus.fifo_rd_en_o), 32'(exp_rd));
    chk("out_valid", 32'(bus.out_valid_o), 32'(ev));
    chk("out_data", 32'(bus.out_data_o), 32'(front.d));
    chk("out_id", 32'(bus.out_id_o), 32'(front.id));
    cyc++;
    if (|bus.fifo_rd_en_o) rdc++;
    if (bus.fifo_rd_en_o[2]) rd2++;
    if (bus.out_valid_o) vcnt++;
    if (bus.out_valid_o && ready) begin
      seen_id.push_back(int'(bus.out_id_o));
      seen_d.push_back(int'(bus.out_data_o));
      seen_cyc.push_back(cyc);
    end
    if (r) begin
      mbuf.delete();
      m_inf = 0;
      m_last = N - 1;
      m_started = 0;
      m_cnt = 0;
    end else begin
      if (fire) void'(mbuf.pop_front());
      if (m_inf) mbuf.push_back(m_inf_e);
      m_inf = |exp_rd;
      m_started = 1;
      if (m_inf) begin
        m_inf_e.id = 2'(pick);
        m_inf_e.d = q[pick].pop_front();
        pend_e = m_inf_e;
        pend_v = 1;
        m_cnt = hold ? m_cnt + 1 : 1;
        m_last = pick;
      end else if (!(mask[m_last] && !emp[m_last])) m_cnt = 0;
    end
  endtask
  task automatic restart();
    for (int i = 0; i < N; i++) q[i].delete();
    seen_id.delete();
    seen_d.delete();
    seen_cyc.delete();
    step(4'b1111, 1'b1, 1'b1);
    rdc = 0;
    rd2 = 0;
    vcnt = 0;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_mask_i = '0;
    bus.fifo_empty_i = '1;
    bus.fifo_rd_data_i = '0;
    bus.out_ready_i = 1'b0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) q[i].push_back(W'(i));
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    // round robin over four FIFOs of three words each
    restart();
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) q[i].push_back(W'(i*16 + k));
    repeat (18) step(4'b1111, 1'b1, 1'b0);
    chk("rr_count", 32'(seen_id.size()), 32'd12);
    for (int i = 0; i < 12 && i < seen_id.size(); i++) begin
      chk("rr_id", 32'(seen_id[i]), 32'(i % 4));
      chk("rr_data", 32'(seen_d[i]), 32'((i % 4)*16 + i/4));
    end
    if (seen_cyc.size() >= 12) chk("rr_span", 32'(seen_cyc[11] - seen_cyc[0]), 32'd11);
    // backpressure: single requester, output stalled
    restart();
    for (int k = 0; k < 5; k++) q[2].push_back(W'(16'h200 + k));
    repeat (8) step(4'b1111, 1'b0, 1'b0);
    chk("stall_reads", 32'(rdc), 32'd2);
    chk("stall_valid", 32'(bus.out_valid_o), 32'd1);
    chk("stall_data", 32'(bus.out_data_o), 32'h200);
    repeat (10) step(4'b1111, 1'b1, 1'b0);
    chk("drain_count", 32'(seen_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_d.size(); i++) chk("drain_data", 32'(seen_d[i]), 32'(16'h200 + i));
    if (seen_cyc.size() >= 5) chk("drain_span", 32'(seen_cyc[4] - seen_cyc[0]), 32'd4);
    // single-word FIFO
    restart();
    q[1].push_back(16'hbeef);
    repeat (8) step(4'b1111, 1'b1, 1'b0);
    chk("single_reads", 32'(rdc), 32'd1);
    chk("single_valid_cycles", 32'(vcnt), 32'd1);
    // masked requester
    restart();
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) q[i].push_back(W'($urandom));
    repeat (20) step(4'b1011, 1'($urandom % 2), 1'b0);
    chk("masked_rd2", 32'(rd2), 32'd0);
    // reset with two words buffered
    restart();
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) q[i].push_back(W'($urandom));
    repeat (5) step(4'b1111, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(bus.out_valid_o), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("first_grant", 32'(bus.fifo_rd_en_o), 32'd1);
`ifdef PE_ARB_BURST_EN
    restart();
    for (int k = 0; k < 4; k++) begin
      q[0].push_back(W'(k));
      q[1].push_back(W'(16 + k));
    end
    repeat (14) step(4'b0011, 1'b1, 1'b0);
    chk("burst_count", 32'(seen_id.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen_id.size(); i++) chk("burst_id", 32'(seen_id[i]), 32'((i / 2) % 2));
`endif
    // random traffic with occasional reset
    restart();
    for (int n = 0; n < 600; n++) begin
      if ($urandom % 3 == 0) q[$urandom % N].push_back(W'($urandom));
      step(4'($urandom), 1'($urandom % 4 != 0), 1'($urandom % 97 == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
